riscv_lsu: RTL and testbench

Load/store unit sitting between the RV32I execute stage and `riscv_dmem`; it is the initiator that drives the data memory's word address, byte select, write data and write enable. It converts a byte address plus funct3 into byte-lane accesses, sign/zero-extends load data, and optionally splits misaligned accesses into two word accesses. A small FSM sequences each request; the core sees a request/done handshake.

---
 rtl/riscv_lsu_pkg.sv | 42 ++++
 rtl/riscv_lsu_align.sv | 47 ++++
 rtl/riscv_lsu.sv | 198 +++++++++++++++++++
 tb/tb_riscv_lsu.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_lsu_pkg.sv
// Shared widths, funct3 codes, FSM state and request payload for the load/store unit.
package riscv_lsu_pkg;

    localparam int unsigned XLEN          = 32;
    localparam int unsigned DMEM_ADDR_BIT = 8;
    localparam int unsigned WADDR_W       = DMEM_ADDR_BIT - 2;
    localparam int unsigned BSEL_W        = XLEN / 8;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC0 = 2'd1,
        ST_ACC1 = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    // Request as latched on acceptance; only the byte offset of the address is kept.
    typedef struct packed {
        logic            we;
        logic [2:0]      funct3;
        logic [1:0]      off;
        logic [XLEN-1:0] wdata;
    } lsu_req_t;

    // Legal RV32I load/store encodings.
    function automatic logic f3_valid(input logic we, input logic [2:0] f3);
        if (we) begin
            return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        end
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Combinational lane math: byte-enable masks, store data shift, load extract/extend.
module riscv_lsu_align
    import riscv_lsu_pkg::*;
(
    input  logic [2:0]        funct3,
    input  logic [1:0]        off,
    input  logic [XLEN-1:0]   wdata,
    input  logic [2*XLEN-1:0] rdata64,
    output logic [BSEL_W-1:0] sel_lo_c,
    output logic [BSEL_W-1:0] sel_hi_c,
    output logic [2*XLEN-1:0] wdata64_c,
    output logic [XLEN-1:0]   load_val_c
);

    logic [BSEL_W-1:0]   size_mask;
    logic [2*BSEL_W-1:0] mask8;
    logic [XLEN-1:0]     shifted;

    // Access size from funct3[1:0]: byte, half, word.
    always_comb begin
        size_mask = 4'hF;
        case (funct3[1:0])
            2'b00:   size_mask = 4'h1;
            2'b01:   size_mask = 4'h3;
            default: size_mask = 4'hF;
        endcase
    end

    assign mask8     = 8'(size_mask) << off;
    assign sel_lo_c  = mask8[BSEL_W-1:0];
    assign sel_hi_c  = mask8[2*BSEL_W-1:BSEL_W];
    assign wdata64_c = {XLEN'(0), wdata} << {off, 3'b000};
    assign shifted   = XLEN'(rdata64 >> {off, 3'b000});

    // Truncate to access size and sign- or zero-extend.
    always_comb begin
        load_val_c = shifted;
        case (funct3)
            F3_LB:   load_val_c = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            F3_LH:   load_val_c = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            F3_LBU:  load_val_c = {(XLEN-8)'(0), shifted[7:0]};
            F3_LHU:  load_val_c = {(XLEN-16)'(0), shifted[15:0]};
            default: load_val_c = shifted;
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// RV32I load/store unit driving riscv_dmem. Optional misaligned-access splitting
// is enabled by defining RISCV_LSU_MISALIGN_EN; otherwise misaligned requests are rejected.
module riscv_lsu
    import riscv_lsu_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_lsu_req,
    input  logic               i_lsu_we,
    input  logic [2:0]         i_lsu_funct3,
    input  logic [XLEN-1:0]    i_lsu_addr,
    input  logic [XLEN-1:0]    i_lsu_wdata,
    output logic [XLEN-1:0]    o_lsu_rdata,
    output logic               o_lsu_done,
    output logic               o_lsu_err,
    output logic               o_lsu_busy,
    output logic [WADDR_W-1:0] o_dmem_addr,
    output logic [XLEN-1:0]    o_dmem_data,
    output logic [BSEL_W-1:0]  o_dmem_byte_sel,
    output logic               o_dmem_wr_en,
    input  logic [XLEN-1:0]    i_dmem_data
);

    lsu_state_e         state_q, state_d;
    lsu_req_t           req_q, req_d;
    logic [XLEN-1:0]    rdata_d;
    logic               done_d, err_d, busy_d;
    logic [WADDR_W-1:0] daddr_d;
    logic [XLEN-1:0]    ddata_d;
    logic [BSEL_W-1:0]  sel_d;
    logic               wr_en_d;

    logic [2:0]         al_f3;
    logic [1:0]         al_off;
    logic [XLEN-1:0]    al_wdata;
    logic [2*XLEN-1:0]  al_rdata64;
    logic [BSEL_W-1:0]  sel_lo_c, sel_hi_c;
    logic [2*XLEN-1:0]  wdata64_c;
    logic [XLEN-1:0]    load_val_c;

    logic               unused_addr;
    assign unused_addr = ^i_lsu_addr[XLEN-1:DMEM_ADDR_BIT];

`ifdef RISCV_LSU_MISALIGN_EN
    logic [XLEN-1:0]    lo_buf_q, lo_buf_d;
`else
    logic               unused_wdata_hi;
    assign unused_wdata_hi = ^wdata64_c[2*XLEN-1:XLEN];
`endif

    // Lane math sees the live request while idle, the latched one afterwards.
    always_comb begin
        al_f3      = req_q.funct3;
        al_off     = req_q.off;
        al_wdata   = req_q.wdata;
        al_rdata64 = {XLEN'(0), i_dmem_data};
        if (state_q == ST_IDLE) begin
            al_f3    = i_lsu_funct3;
            al_off   = i_lsu_addr[1:0];
            al_wdata = i_lsu_wdata;
        end
`ifdef RISCV_LSU_MISALIGN_EN
        if (state_q == ST_ACC1) begin
            al_rdata64 = {i_dmem_data, lo_buf_q};
        end
`endif
    end

    riscv_lsu_align u_align (
        .funct3     (al_f3),
        .off        (al_off),
        .wdata      (al_wdata),
        .rdata64    (al_rdata64),
        .sel_lo_c   (sel_lo_c),
        .sel_hi_c   (sel_hi_c),
        .wdata64_c  (wdata64_c),
        .load_val_c (load_val_c)
    );

    // State register.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and next values of every registered output.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        rdata_d = o_lsu_rdata;
        done_d  = 1'b0;
        err_d   = 1'b0;
        daddr_d = o_dmem_addr;
        ddata_d = o_dmem_data;
        sel_d   = '0;
        wr_en_d = 1'b0;
`ifdef RISCV_LSU_MISALIGN_EN
        lo_buf_d = lo_buf_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (i_lsu_req) begin
                    req_d.we     = i_lsu_we;
                    req_d.funct3 = i_lsu_funct3;
                    req_d.off    = i_lsu_addr[1:0];
                    req_d.wdata  = i_lsu_wdata;
                    if (!f3_valid(i_lsu_we, i_lsu_funct3)) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
`ifndef RISCV_LSU_MISALIGN_EN
                    end else if (sel_hi_c != '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
`endif
                    end else begin
                        state_d = ST_ACC0;
                        daddr_d = i_lsu_addr[DMEM_ADDR_BIT-1:2];
                        ddata_d = wdata64_c[XLEN-1:0];
                        sel_d   = sel_lo_c;
                        wr_en_d = i_lsu_we;
                    end
                end
            end
            ST_ACC0: begin
`ifdef RISCV_LSU_MISALIGN_EN
                if (sel_hi_c != '0) begin
                    state_d  = ST_ACC1;
                    lo_buf_d = i_dmem_data;
                    daddr_d  = o_dmem_addr + WADDR_W'(1);
                    ddata_d  = wdata64_c[2*XLEN-1:XLEN];
                    sel_d    = sel_hi_c;
                    wr_en_d  = req_q.we;
                end else
`endif
                begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    if (!req_q.we) begin
                        rdata_d = load_val_c;
                    end
                end
            end
`ifdef RISCV_LSU_MISALIGN_EN
            ST_ACC1: begin
                state_d = ST_DONE;
                done_d  = 1'b1;
                if (!req_q.we) begin
                    rdata_d = load_val_c;
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Request latch, load buffer and output registers.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            req_q           <= '0;
            o_lsu_rdata     <= '0;
            o_lsu_done      <= 1'b0;
            o_lsu_err       <= 1'b0;
            o_lsu_busy      <= 1'b0;
            o_dmem_addr     <= '0;
            o_dmem_data     <= '0;
            o_dmem_byte_sel <= '0;
            o_dmem_wr_en    <= 1'b0;
`ifdef RISCV_LSU_MISALIGN_EN
            lo_buf_q        <= '0;
`endif
        end else begin
            req_q           <= req_d;
            o_lsu_rdata     <= rdata_d;
            o_lsu_done      <= done_d;
            o_lsu_err       <= err_d;
            o_lsu_busy      <= busy_d;
            o_dmem_addr     <= daddr_d;
            o_dmem_data     <= ddata_d;
            o_dmem_byte_sel <= sel_d;
            o_dmem_wr_en    <= wr_en_d;
`ifdef RISCV_LSU_MISALIGN_EN
            lo_buf_q        <= lo_buf_d;
`endif
        end
    end

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu with a byte-enabled word memory model.
module tb_riscv_lsu;
    import riscv_lsu_pkg::*;

    logic               clk;
    logic               rst_n;
    logic               req;
    logic               we;
    logic [2:0]         f3;
    logic [XLEN-1:0]    addr;
    logic [XLEN-1:0]    wdata;
    logic [XLEN-1:0]    rdata;
    logic               done;
    logic               err;
    logic               busy;
    logic [WADDR_W-1:0] dmem_addr;
    logic [XLEN-1:0]    dmem_wdata;
    logic [BSEL_W-1:0]  sel;
    logic               wr_en;
    logic [XLEN-1:0]    dmem_rdata;

    logic [XLEN-1:0]    mem [2**WADDR_W] = '{default: '0};

    int n_checks = 0;
    int n_errors = 0;

    int                 r_cycles;
    int                 r_nacc;
    logic               r_err;
    logic               r_wr;
    logic               r_busy;
    logic [XLEN-1:0]    r_rdata;
    logic [BSEL_W-1:0]  r_sel0, r_sel1;
    logic [WADDR_W-1:0] r_wa0, r_wa1;

    riscv_lsu dut (
        .i_clk           (clk),
        .i_rstn          (rst_n),
        .i_lsu_req       (req),
        .i_lsu_we        (we),
        .i_lsu_funct3    (f3),
        .i_lsu_addr      (addr),
        .i_lsu_wdata     (wdata),
        .o_lsu_rdata     (rdata),
        .o_lsu_done      (done),
        .o_lsu_err       (err),
        .o_lsu_busy      (busy),
        .o_dmem_addr     (dmem_addr),
        .o_dmem_data     (dmem_wdata),
        .o_dmem_byte_sel (sel),
        .o_dmem_wr_en    (wr_en),
        .i_dmem_data     (dmem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign dmem_rdata = mem[dmem_addr];

    always @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < BSEL_W; b++) begin
                if (sel[b]) mem[dmem_addr][8*b +: 8] <= dmem_wdata[8*b +: 8];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Issue one request, track dmem activity until done, then step past DONE.
    task automatic run_req(input logic w, input logic [2:0] fn,
                           input logic [31:0] a, input logic [31:0] d);
        int cyc;
        @(negedge clk);
        req = 1'b1; we = w; f3 = fn; addr = a; wdata = d;
        @(posedge clk); #1;
        req = 1'b0;
        cyc = 1; r_nacc = 0; r_wr = 1'b0; r_busy = busy;
        r_sel0 = '0; r_sel1 = '0; r_wa0 = '0; r_wa1 = '0;
        while (!done && cyc < 10) begin
            if (sel != '0) begin
                if (r_nacc == 0) begin r_sel0 = sel; r_wa0 = dmem_addr; end
                else begin r_sel1 = sel; r_wa1 = dmem_addr; end
                r_nacc++;
            end
            if (wr_en) r_wr = 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        if (!done) check("timeout", 32'(done), 32'd1);
        r_cycles = cyc;
        r_err    = err;
        r_rdata  = rdata;
        @(posedge clk); #1;
        check("idle_after", {30'd0, done, busy}, 32'd0);
    endtask

    initial begin
        int cyc;
        logic saw_done;
        rst_n = 1'b0; req = 1'b0; we = 1'b0; f3 = '0; addr = '0; wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rdata", rdata, 32'd0);
        check("rst_flags", {28'd0, done, err, busy, wr_en}, 32'd0);
        check("rst_dmem", {22'd0, dmem_addr, sel}, 32'd0);
        check("rst_wdata", dmem_wdata, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        run_req(1'b1, F3_SW, 32'h0, 32'h11223344);
        check("sw0_err", 32'(r_err), 32'd0);

        run_req(1'b1, F3_SW, 32'h8, 32'hDEADBEEF);
        check("sw8_cycles", r_cycles, 32'd2);
        check("sw8_busy", 32'(r_busy), 32'd1);
        check("sw8_acc", {r_nacc[7:0], 4'd0, r_sel0, 2'd0, r_wa0, 7'd0, r_wr}, {8'd1, 4'd0, 4'hF, 2'd0, 6'd2, 7'd0, 1'b1});
        check("sw8_mem", mem[2], 32'hDEADBEEF);

        run_req(1'b0, F3_LW, 32'h8, 32'h0);
        check("lw8_rdata", r_rdata, 32'hDEADBEEF);
        check("lw8_cyc_wr", {r_cycles[15:0], 15'd0, r_wr}, {16'd2, 16'd0});

        run_req(1'b1, F3_SB, 32'h5, 32'h77777780);
        check("sb5_sel", {r_sel0, 2'd0, r_wa0}, {4'b0010, 2'd0, 6'd1});
        check("sb5_mem", mem[1], 32'h00008000);
        run_req(1'b0, F3_LB, 32'h5, 32'h0);
        check("lb5", r_rdata, 32'hFFFFFF80);
        run_req(1'b0, F3_LBU, 32'h5, 32'h0);
        check("lbu5", r_rdata, 32'h00000080);

        run_req(1'b1, F3_SH, 32'h2, 32'h00001234);
        check("sh2_sel", 32'(r_sel0), 32'hC);
        check("sh2_mem", mem[0], 32'h12343344);
        run_req(1'b0, F3_LH, 32'h2, 32'h0);
        check("lh2", r_rdata, 32'h00001234);
        run_req(1'b0, F3_LB, 32'h3, 32'h0);
        check("lb3", r_rdata, 32'h00000012);
        run_req(1'b0, F3_LH, 32'h0, 32'h0);
        check("lh0", r_rdata, 32'h00003344);

        run_req(1'b1, F3_SW, 32'hFC, 32'h55667788);
        check("sw63_mem", mem[63], 32'h55667788);

        run_req(1'b1, F3_SW, 32'h6, 32'hAABBCCDD);
`ifdef RISCV_LSU_MISALIGN_EN
        check("sw6_cycles", r_cycles, 32'd3);
        check("sw6_err", 32'(r_err), 32'd0);
        check("sw6_acc0", {r_sel0, 2'd0, r_wa0}, {4'b1100, 2'd0, 6'd1});
        check("sw6_acc1", {r_sel1, 2'd0, r_wa1}, {4'b0011, 2'd0, 6'd2});
        check("sw6_mem1", mem[1], 32'hCCDD8000);
        check("sw6_mem2", mem[2], 32'hDEADAABB);
        run_req(1'b0, F3_LW, 32'h6, 32'h0);
        check("lw6", r_rdata, 32'hAABBCCDD);
        check("lw6_cycles", r_cycles, 32'd3);
        run_req(1'b0, F3_LHU, 32'hFF, 32'h0);
        check("lhuff", r_rdata, 32'h00004455);
        check("lhuff_wrap", {r_sel0, 2'd0, r_wa0, r_sel1, 2'd0, r_wa1}, {4'b1000, 2'd0, 6'd63, 4'b0001, 2'd0, 6'd0});
`else
        check("sw6_err", {r_cycles[15:0], 15'd0, r_err}, {16'd1, 16'd1});
        check("sw6_noacc", {r_nacc[15:0], 15'd0, r_wr}, 32'd0);
        check("sw6_mem1", mem[1], 32'h00008000);
        run_req(1'b0, F3_LHU, 32'hFF, 32'h0);
        check("lhuff_err", {r_cycles[15:0], 15'd0, r_err}, {16'd1, 16'd1});
        check("lhuff_hold", r_rdata, 32'h00003344);
`endif

        run_req(1'b0, 3'b011, 32'h8, 32'h0);
        check("ld011_err", {r_cycles[15:0], 15'd0, r_err}, {16'd1, 16'd1});
        check("ld011_noacc", r_nacc, 32'd0);
        run_req(1'b1, 3'b100, 32'h8, 32'h0);
        check("st100_err", {r_cycles[15:0], 15'd0, r_err}, {16'd1, 16'd1});
        check("st100_mem", mem[2], mem[2] === 32'hDEADBEEF || mem[2] === 32'hDEADAABB ? mem[2] : 32'hDEADBEEF);

        // Request held high across the busy window must not start a second access.
        @(negedge clk);
        req = 1'b1; we = 1'b1; f3 = F3_SW; addr = 32'h10; wdata = 32'h01020304;
        @(posedge clk); #1;
        addr = 32'h14; wdata = 32'hFFFFFFFF;
        cyc = 1;
        while (!done && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        req = 1'b0;
        check("busy_ign_cyc", cyc, 32'd2);
        repeat (2) @(posedge clk);
        #1;
        check("busy_ign_idle", {30'd0, busy, wr_en}, 32'd0);
        check("busy_ign_mem4", mem[4], 32'h01020304);
        check("busy_ign_mem5", mem[5], 32'h00000000);

        // Reset during ACC0 of a store.
        @(negedge clk);
        req = 1'b1; we = 1'b1; f3 = F3_SW; addr = 32'h20; wdata = 32'h00000099;
        @(posedge clk); #1;
        req = 1'b0;
        check("rst_mid_pre", {31'd0, wr_en}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_now", {28'd0, wr_en, busy, done, err}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        check("rst_mid_nodone", 32'(saw_done), 32'd0);
        check("rst_mid_mem", mem[8], 32'h00000000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
